// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for a loadable up/down counter: loads lo, then drives the
// counter lo->hi->lo a latched number of times and pulses done when finished.
module updown_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CYC_W-1:0] cycles,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CYC_W-1:0]   sweep_q, sweep_d;
    logic               err_q, err_d;

    logic [WIDTH-1:0]   top_turn;
    logic [WIDTH-1:0]   bot_turn;
    logic [CYC_W-1:0]   sweep_inc;
    logic               start_ok;

    // lo < hi is guaranteed for any accepted start, so neither turn point wraps.
    assign top_turn  = hi_q - WIDTH'(1);
    assign bot_turn  = lo_q + WIDTH'(1);
    assign sweep_inc = sweep_q + CYC_W'(1);
    assign start_ok  = (lo < hi) && (cycles != '0);

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cyc_d   = cyc_q;
        sweep_d = sweep_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        lo_d    = lo;
                        hi_d    = hi;
                        cyc_d   = cycles;
                        sweep_d = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                state_d = abort ? S_IDLE : S_UP;
            end
            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == top_turn) begin
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == bot_turn) begin
                    sweep_d = sweep_inc;
                    state_d = (sweep_inc == cyc_q) ? S_DONE : S_UP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            cyc_q   <= '0;
            sweep_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cyc_q   <= cyc_d;
            sweep_q <= sweep_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs: everything drops to zero as soon as reset pulls state to IDLE.
    assign cnt_load     = (state_q == S_LOAD);
    assign cnt_en       = (state_q == S_UP) || (state_q == S_DOWN);
    assign cnt_up       = (state_q == S_UP);
    assign busy         = (state_q == S_LOAD) || cnt_en;
    assign done         = (state_q == S_DONE);
    assign err          = err_q;
    assign cnt_load_val = lo_q;

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Sequencer for the team's 4-bit up/down counter datapath. The counter variant used here has synchronous load and enable.
On a start request, the block loads the counter with a low bound, then drives direction and enable so the counter sweeps lo→hi→lo a programmed number of times, and signals completion.
It sits between a host/test FSM and the counter; it owns the counter's x/enable/load inputs and observes the counter value.

Parameters:
WIDTH, 4, width of counter value and bound inputs
CYC_W, 4, width of sweep-count input and internal sweep counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request pulse/level; sampled only in IDLE
abort  in  1  synchronous abort; valid in any non-IDLE state
lo  in  WIDTH  sweep low bound, latched on accepted start
hi  in  WIDTH  sweep high bound, latched on accepted start
cycles  in  CYC_W  number of full lo→hi→lo sweeps, latched on accepted start
cnt_q  in  WIDTH  current counter value, from the counter
cnt_load  out  1  counter synchronous load strobe
cnt_load_val  out  WIDTH  value to load (equals latched lo)
cnt_en  out  1  counter count enable
cnt_up  out  1  direction to counter (x): 1 = up, 0 = down
busy  out  1  high in LOAD/UP/DOWN
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: start rejected

Behaviour:
- States: IDLE, LOAD, UP, DOWN, DONE. Outputs are Moore-decoded from state and latched registers.
  - cnt_load = LOAD; cnt_en = UP|DOWN; cnt_up = UP; busy = LOAD|UP|DOWN; done = DONE.
  - cnt_load_val = lo_r.
- Reset (reset=0, asynchronous, any time including mid-sweep):
  - state = IDLE; lo_r, hi_r, cyc_r and the sweep counter = 0.
  - err register = 0; all outputs 0.
- IDLE:
  - start=1 with lo<hi and cycles≠0: latch lo/hi/cycles, clear sweep counter, go to LOAD.
  - start=1 with lo≥hi or cycles=0: err=1 for the next cycle only; stay IDLE; latches unchanged.
  - abort is ignored in IDLE.
- LOAD: one cycle, then UP. The counter equals lo_r after the edge.
- UP:
  - If cnt_q == hi_r−1 at the edge, go to DOWN (counter becomes hi_r); else stay.
  - UP always lasts hi_r−lo_r cycles.
- DOWN:
  - If cnt_q == lo_r+1 at the edge, increment the sweep counter (counter becomes lo_r).
  - Then go to DONE if the incremented count == cyc_r; else go to UP.
- DONE: one cycle, then IDLE. The counter holds lo_r.
- Timing:
  - Latency from accepted start to done = 1 + 2·(hi_r−lo_r)·cyc_r + 1 cycles.
  - busy rises the cycle after start is accepted.
- start while not IDLE: ignored; latched values are not disturbed by input changes.
- abort=1 in LOAD/UP/DOWN/DONE: next state IDLE; no done pulse; the counter freezes at its value at that edge.
- abort and a completion edge in the same cycle: abort wins (no done).
- Arithmetic: comparisons are WIDTH-bit unsigned. hi_r−1 and lo_r+1 cannot wrap because lo<hi is enforced at start.
- No wrap-around of the counter ever occurs under control of this block.
- cnt_q is assumed valid and in-range. If cnt_q skips the compare value (external corruption), the block keeps counting and the counter wraps 15→0. No error detection is required.

Test Plan:
- reset low then high; lo=2, hi=5, cycles=1; start pulse at cycle 0 → cnt_load=1 in cycle 1; cnt_q after edges = 2,3,4,5,4,3,2; cnt_up=1 cycles 2–4, 0 cycles 5–7; busy=1 cycles 1–7; done=1 only cycle 8.
- lo=0, hi=15, cycles=2 → busy for 61 cycles; cnt_q peaks 15 twice, returns to 0; single done pulse; no wrap to 0 from 15 upward.
- lo=14, hi=15, cycles=3 → cnt_q toggles 14,15,14,15,14,15,14; UP/DOWN each 1 cycle; done after 8 cycles.
- start with lo=5, hi=5, and separately cycles=0 → err=1 for exactly one cycle; busy, cnt_en and cnt_load stay 0; state remains IDLE.
- Mid-sweep abort in UP with cnt_q=4, and separately mid-sweep start with new bounds → after abort, cnt_en=0 next cycle, no done, cnt_q frozen. The new start is ignored and the sweep finishes with the original bounds.
- reset asserted asynchronously (between clock edges) during DOWN → all outputs 0 immediately. After release, a new start (lo=1, hi=3, cycles=1) runs the normal sequence 1,2,3,2,1.
